uart_tx_fifo: RTL and testbench

- Parametrised successor to the team's single-byte 8N1 UART transmitter.
- Configurable data width, parity and stop-bit count at elaboration time.
- Internal transmit FIFO so software-side logic can queue several characters; back-to-back frames go out with no idle gap.
- Sits between a byte producer and the tx pin; timed by the shared 16x baud-rate generator tick.

---
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an internal transmit FIFO.
// Frames are start, DATA_BITS data (LSB first), optional parity, then STOP_BITS stop bits, timed by a 16x baud tick.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 brg16_tick,
    input  logic [DATA_BITS-1:0] d,
    input  logic                 d_tick,
    output logic                 full,
    output logic                 tx_empty,
    output logic                 tx_done_tick,
    output logic                 overrun_tick,
    output logic                 tx
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {GUARD, IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [3:0]           tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] head;

    logic bit_end;
    logic last_stop;
    logic fifo_nonempty;
    logic pop;
    logic push;

    // Write side: d_tick is a one-clk strobe with no back-pressure. The byte is
    // taken when a slot is free (or being freed by a pop in the same clk);
    // otherwise it is dropped and overrun_tick pulses in the next clk.
    assign head          = mem[rd_ptr];
    assign bit_end       = brg16_tick && (tick_cnt == 4'd15);
    assign last_stop     = (state == STOP) && bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign fifo_nonempty = (count != '0);
    assign pop           = fifo_nonempty && (((state == IDLE) && brg16_tick) || last_stop);
    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign push          = d_tick && (!full || pop);
    assign tx_empty      = (state == IDLE) && !fifo_nonempty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overrun_tick <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count        <= count + CNT_W'(push) - CNT_W'(pop);
            overrun_tick <= d_tick && !push;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d;
    end

    // The tick counter idles at 0 so a pop from IDLE starts a full 16-tick start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= GUARD;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            if (brg16_tick && (state != IDLE)) tick_cnt <= tick_cnt + 4'd1;
            if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ (PARITY == 1);
            end
            unique case (state)
                GUARD: begin
                    if (bit_end) state <= IDLE;
                end
                IDLE: begin
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        tx_done_tick <= 1'b1;
                        bit_cnt      <= '0;
                        if (pop) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bit_end) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state <= GUARD;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 7E2, 9O1) share clock, tick and reset;
// frames are decoded from the line by mid-bit sampling and compared with frames built from the character.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int TICK_CLKS = 20;
    localparam int BIT_CLKS  = 16 * TICK_CLKS;
    localparam int DEPTH     = 4;
    localparam int WAIT_LIM  = 4 * BIT_CLKS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       brg16_tick = 1'b0;
    logic [7:0] d_a = '0;
    logic [6:0] d_b = '0;
    logic [8:0] d_c = '0;
    logic       d_tick_a = 1'b0, d_tick_b = 1'b0, d_tick_c = 1'b0;
    logic       full_a, tx_empty_a, done_a, ovr_a, tx_a;
    logic       full_b, tx_empty_b, done_b, ovr_b, tx_b;
    logic       full_c, tx_empty_c, done_c, ovr_c, tx_c;

    int cyc = 0;
    int sel = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    logic tx_sel, done_sel;

    assign tx_sel   = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
    assign done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .brg16_tick(brg16_tick), .d(d_a), .d_tick(d_tick_a),
        .full(full_a), .tx_empty(tx_empty_a), .tx_done_tick(done_a), .overrun_tick(ovr_a), .tx(tx_a));
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .brg16_tick(brg16_tick), .d(d_b), .d_tick(d_tick_b),
        .full(full_b), .tx_empty(tx_empty_b), .tx_done_tick(done_b), .overrun_tick(ovr_b), .tx(tx_b));
    uart_tx_fifo #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_c (
        .clk(clk), .reset(reset), .brg16_tick(brg16_tick), .d(d_c), .d_tick(d_tick_c),
        .full(full_c), .tx_empty(tx_empty_c), .tx_done_tick(done_c), .overrun_tick(ovr_c), .tx(tx_c));

    // Clock and reset-free tick generator: tick is sampled at the posedge following a negedge with cyc%TICK_CLKS==0.
    initial begin
        forever #41.667 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1 brg16_tick = ((cyc % TICK_CLKS) == 0);
        end
    end

    initial begin
        #15000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Expected line pattern of one frame, bit i = i-th bit period (start first), stop and beyond = 1.
    function automatic logic [15:0] frame_bits(input logic [8:0] v, input int db, input int par);
        logic [15:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < db; i++) begin
            f[1 + i] = v[i];
            ones += int'(v[i]);
        end
        if (par == 1) f[1 + db] = ((ones % 2) == 0);
        else if (par == 2) f[1 + db] = ((ones % 2) == 1);
        return f;
    endfunction

    task automatic wait_phase(input int p);
        @(negedge clk);
        while ((cyc % TICK_CLKS) != p) @(negedge clk);
    endtask

    // Line monitor: finds the start edge (unless already on it), samples every bit mid-period,
    // counts done pulses up to the frame end; optionally writes inj_val into dut_a right before the last stop tick.
    task automatic capture(input int n, input bit started, input bit inject, input logic [7:0] inj_val,
                           output logic [15:0] raw, output bit found, output int start_cyc,
                           output int done_cyc, output int done_cnt, output bit next_started);
        int w;
        raw = '1; found = 1'b0; start_cyc = 0; done_cyc = 0; done_cnt = 0; next_started = 1'b0;
        w = 0;
        if (!started) begin
            while (tx_sel !== 1'b0 && w < WAIT_LIM) begin
                @(negedge clk);
                w++;
            end
        end
        if (tx_sel !== 1'b0) return;
        found = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k <= n * BIT_CLKS; k++) begin
            if (k > 0) @(negedge clk);
            if (k > 0 && done_sel === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if ((k % BIT_CLKS) == BIT_CLKS / 2 && (k / BIT_CLKS) < n) raw[k / BIT_CLKS] = tx_sel;
            if (inject && k == n * BIT_CLKS - 1) begin
                d_a = inj_val;
                d_tick_a = 1'b1;
            end
            if (inject && k == n * BIT_CLKS) d_tick_a = 1'b0;
        end
        next_started = (tx_sel === 1'b0);
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        int c0, rise;
        bit low_seen;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        obs = {tx_a, full_a, tx_empty_a, done_a, ovr_a, tx_b, tx_c};
        n_checks++;
        if (obs !== 7'b1000011) $display("FAIL reset_values: got %b want 1000011", obs);
        else n_pass++;
        reset = 1'b1;
        c0 = cyc;
        rise = -1;
        low_seen = 1'b0;
        for (int k = 0; k < 16 * TICK_CLKS + 4 && rise < 0; k++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) low_seen = 1'b1;
            if (tx_empty_a === 1'b1) rise = cyc - c0;
        end
        n_checks++;
        if (low_seen) $display("FAIL guard_line: tx went low during guard, want constant 1");
        else n_pass++;
        n_checks++;
        if (rise < 15 * TICK_CLKS + 1 || rise > 16 * TICK_CLKS)
            $display("FAIL guard_len: tx_empty rose after %0d clks, want %0d..%0d", rise, 15 * TICK_CLKS + 1, 16 * TICK_CLKS);
        else n_pass++;
        n_checks++;
        if ({tx_empty_b, tx_empty_c} !== 2'b11) $display("FAIL guard_bc: tx_empty b/c got %b want 11", {tx_empty_b, tx_empty_c});
        else n_pass++;
    endtask

    task automatic test_single_frame(input logic [7:0] v);
        logic [15:0] raw;
        bit found, ns;
        int sc, dc, dn;
        sel = 0;
        wait_phase(5);
        n_checks++;
        if (tx_empty_a !== 1'b1) $display("FAIL single_idle_empty: got %b want 1", tx_empty_a);
        else n_pass++;
        d_a = v;
        d_tick_a = 1'b1;
        @(negedge clk);
        d_tick_a = 1'b0;
        n_checks++;
        if (tx_empty_a !== 1'b0) $display("FAIL single_empty_drop: got %b want 0", tx_empty_a);
        else n_pass++;
        capture(10, 1'b0, 1'b0, 8'h00, raw, found, sc, dc, dn, ns);
        n_checks++;
        if (!found) $display("FAIL single_start: no start bit within %0d clks, want one", WAIT_LIM);
        else n_pass++;
        n_checks++;
        if (raw !== frame_bits({1'b0, v}, 8, 0)) $display("FAIL single_bits %h: got %b want %b", v, raw, frame_bits({1'b0, v}, 8, 0));
        else n_pass++;
        n_checks++;
        if (dn != 1 || dc - sc != 10 * BIT_CLKS)
            $display("FAIL single_done: got %0d pulses at %0d clks want 1 at %0d", dn, dc - sc, 10 * BIT_CLKS);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_empty_a !== 1'b1 || tx_a !== 1'b1) $display("FAIL single_after: tx_empty,tx got %b%b want 11", tx_empty_a, tx_a);
        else n_pass++;
    endtask

    task automatic test_parity(input int which);
        logic [15:0] raw;
        logic [8:0] v;
        bit found, ns;
        int sc, dc, dn, db, par, n;
        sel = which;
        db  = (which == 1) ? 7 : 9;
        par = (which == 1) ? 2 : 1;
        n   = 1 + db + 1 + ((which == 1) ? 2 : 1);
        for (int t = 0; t < 2; t++) begin
            if (t == 0) v = (which == 1) ? 9'h055 : 9'h1FF;
            else v = 9'($urandom_range(0, (1 << db) - 1));
            wait_phase(5);
            if (which == 1) begin
                d_b = v[6:0];
                d_tick_b = 1'b1;
            end else begin
                d_c = v;
                d_tick_c = 1'b1;
            end
            @(negedge clk);
            d_tick_b = 1'b0;
            d_tick_c = 1'b0;
            capture(n, 1'b0, 1'b0, 8'h00, raw, found, sc, dc, dn, ns);
            n_checks++;
            if (!found) $display("FAIL parity%0d_start: no start bit, want one", which);
            else n_pass++;
            n_checks++;
            if (raw !== frame_bits(v, db, par)) $display("FAIL parity%0d_bits %h: got %b want %b", which, v, raw, frame_bits(v, db, par));
            else n_pass++;
            n_checks++;
            if (dn != 1 || dc - sc != n * BIT_CLKS)
                $display("FAIL parity%0d_done: got %0d pulses at %0d clks want 1 at %0d", which, dn, dc - sc, n * BIT_CLKS);
            else n_pass++;
            n_checks++;
            if (ns) $display("FAIL parity%0d_idle: got a following start, want idle line", which);
            else n_pass++;
        end
    endtask

    task automatic test_burst_overrun();
        logic [15:0] raw;
        logic [7:0] v;
        bit found, ns;
        int sc, dc, dn, acc, drops, ovr_cnt;
        sel = 0;
        acc = 0;
        drops = 0;
        ovr_cnt = 0;
        exp_q.delete();
        wait_phase(1);
        for (int i = 0; i <= DEPTH; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (full_a !== (acc == DEPTH)) $display("FAIL burst_full%0d: got %b want %b", i, full_a, acc == DEPTH);
            else n_pass++;
            v = 8'($urandom_range(0, 255));
            d_a = v;
            d_tick_a = 1'b1;
            if (acc < DEPTH) begin
                exp_q.push_back(v);
                acc++;
            end else drops++;
        end
        @(negedge clk);
        d_tick_a = 1'b0;
        n_checks++;
        if (ovr_a !== 1'b1 || full_a !== 1'b1) $display("FAIL burst_ovr_now: ovr,full got %b%b want 11", ovr_a, full_a);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (ovr_a === 1'b1) ovr_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (ovr_cnt != drops) $display("FAIL burst_ovr_cnt: got %0d want %0d", ovr_cnt, drops);
        else n_pass++;
        ns = 1'b0;
        for (int f = 0; f < DEPTH; f++) begin
            capture(10, ns, 1'b0, 8'h00, raw, found, sc, dc, dn, ns);
            v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            n_checks++;
            if (!found || raw !== frame_bits({1'b0, v}, 8, 0))
                $display("FAIL burst_frame%0d: got %b want %b", f, raw, frame_bits({1'b0, v}, 8, 0));
            else n_pass++;
            n_checks++;
            if (dn != 1 || dc - sc != 10 * BIT_CLKS)
                $display("FAIL burst_done%0d: got %0d pulses at %0d clks want 1 at %0d", f, dn, dc - sc, 10 * BIT_CLKS);
            else n_pass++;
            n_checks++;
            if (ns !== (f < DEPTH - 1)) $display("FAIL burst_gap%0d: next start now got %b want %b", f, ns, f < DEPTH - 1);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (tx_empty_a !== 1'b1 || full_a !== 1'b0) $display("FAIL burst_end: tx_empty,full got %b%b want 10", tx_empty_a, full_a);
        else n_pass++;
    endtask

    task automatic test_tick_align();
        logic [15:0] raw;
        logic [7:0] v1, v2;
        bit found, ns;
        int sc, dc, dn, c0, dc1;
        sel = 0;
        v1 = 8'($urandom_range(0, 255));
        v2 = 8'($urandom_range(0, 255));
        wait_phase(0);
        c0 = cyc;
        d_a = v1;
        d_tick_a = 1'b1;
        @(negedge clk);
        d_tick_a = 1'b0;
        capture(10, 1'b0, 1'b1, v2, raw, found, sc, dc, dn, ns);
        n_checks++;
        if (!found || sc - c0 != TICK_CLKS + 1)
            $display("FAIL align_idle_start: start %0d clks after write, want %0d", sc - c0, TICK_CLKS + 1);
        else n_pass++;
        n_checks++;
        if (raw !== frame_bits({1'b0, v1}, 8, 0) || dn != 1)
            $display("FAIL align_frame1: got %b (%0d done) want %b (1 done)", raw, dn, frame_bits({1'b0, v1}, 8, 0));
        else n_pass++;
        n_checks++;
        if (ns) $display("FAIL align_stop_gap: got immediate start, want one tick gap");
        else n_pass++;
        dc1 = dc;
        capture(10, 1'b0, 1'b0, 8'h00, raw, found, sc, dc, dn, ns);
        n_checks++;
        if (!found || sc - dc1 != TICK_CLKS)
            $display("FAIL align_stop_start: start %0d clks after done, want %0d", sc - dc1, TICK_CLKS);
        else n_pass++;
        n_checks++;
        if (raw !== frame_bits({1'b0, v2}, 8, 0) || dn != 1)
            $display("FAIL align_frame2: got %b (%0d done) want %b (1 done)", raw, dn, frame_bits({1'b0, v2}, 8, 0));
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] vals [3];
        int w, c0, rise;
        bit low_seen, done_seen;
        sel = 0;
        vals[0] = 8'h00;
        vals[1] = 8'h5A;
        vals[2] = 8'h3C;
        wait_phase(1);
        for (int i = 0; i < 3; i++) begin
            d_a = vals[i];
            d_tick_a = 1'b1;
            @(negedge clk);
        end
        d_tick_a = 1'b0;
        w = 0;
        while (tx_a !== 1'b0 && w < WAIT_LIM) begin
            @(negedge clk);
            w++;
        end
        repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        n_checks++;
        if (tx_a !== 1'b0) $display("FAIL midreset_pre: tx got %b want 0 in data of 0x00", tx_a);
        else n_pass++;
        #5 reset = 1'b0;
        #1;
        n_checks++;
        if ({tx_a, full_a, tx_empty_a} !== 3'b100) $display("FAIL midreset_async: tx,full,tx_empty got %b want 100", {tx_a, full_a, tx_empty_a});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        c0 = cyc;
        rise = -1;
        low_seen = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 16 * TICK_CLKS + 2 * BIT_CLKS; k++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) low_seen = 1'b1;
            if (done_a === 1'b1) done_seen = 1'b1;
            if (rise < 0 && tx_empty_a === 1'b1) rise = cyc - c0;
        end
        n_checks++;
        if (rise < 15 * TICK_CLKS + 1 || rise > 16 * TICK_CLKS)
            $display("FAIL midreset_guard: tx_empty rose after %0d clks, want %0d..%0d", rise, 15 * TICK_CLKS + 1, 16 * TICK_CLKS);
        else n_pass++;
        n_checks++;
        if (low_seen || done_seen) $display("FAIL midreset_flush: line low %b, done %b, want 0 0", low_seen, done_seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame(8'h81);
        test_single_frame(8'($urandom_range(0, 255)));
        test_parity(1);
        test_parity(2);
        test_burst_overrun();
        test_tick_align();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
